// File: rtl/fetch_if.sv
// Fetch-stage bus: the branch/stall controls, the instruction-memory link and the IF/ID outputs.
interface fetch_if #(
  parameter int ADDR_SIZE = 32,
  parameter int INST_SIZE = 32,
  parameter int CNT_SIZE  = 16
);
  logic                 freeze;
  logic                 branch_taken;
  logic [ADDR_SIZE-1:0] branch_addr;
  logic [ADDR_SIZE-1:0] inst_addr;
  logic [INST_SIZE-1:0] inst_in;
  logic [ADDR_SIZE-1:0] if_id_pc;
  logic [INST_SIZE-1:0] if_id_inst;
  logic                 if_id_valid;
  logic [CNT_SIZE-1:0]  fetch_count;
  logic [CNT_SIZE-1:0]  flush_count;

  // Environment side: hazard unit, EXE redirect and instruction memory.
  modport master (
    output freeze, branch_taken, branch_addr, inst_in,
    input  inst_addr, if_id_pc, if_id_inst, if_id_valid, fetch_count, flush_count
  );

  // Fetch stage side.
  modport slave (
    input  freeze, branch_taken, branch_addr, inst_in,
    output inst_addr, if_id_pc, if_id_inst, if_id_valid, fetch_count, flush_count
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, zero-latency imem address,
// IF/ID pipeline register with stall/flush, and fetch/flush event counters.
module fetch_stage #(
  parameter int                   ADDR_SIZE = 32,
  parameter int                   INST_SIZE = 32,
  parameter logic [ADDR_SIZE-1:0] RESET_PC  = '0,
  parameter int                   CNT_SIZE  = 16
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.slave   bus
);

  logic [ADDR_SIZE-1:0] r_pc;
  logic [ADDR_SIZE-1:0] r_if_pc;
  logic [INST_SIZE-1:0] r_if_inst;
  logic                 r_if_valid;
  logic [CNT_SIZE-1:0]  r_fetch_cnt;
  logic [CNT_SIZE-1:0]  r_flush_cnt;

  logic [ADDR_SIZE-1:0] w_pc_plus4;
  logic [ADDR_SIZE-1:0] w_branch_tgt;

  // Sequential PC; the add wraps naturally at the address width.
  assign w_pc_plus4   = r_pc + ADDR_SIZE'(4);
  // Unaligned redirect targets are silently forced to a word boundary.
  assign w_branch_tgt = {bus.branch_addr[ADDR_SIZE-1:2], 2'b00};

  // PC, IF/ID and counters: reset > branch flush > freeze hold > normal fetch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc        <= RESET_PC;
      r_if_pc     <= '0;
      r_if_inst   <= '0;
      r_if_valid  <= 1'b0;
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (bus.branch_taken) begin
      // Redirect wins over a stall; the wrong-path word in IF/ID becomes a bubble.
      r_pc        <= w_branch_tgt;
      r_if_pc     <= '0;
      r_if_inst   <= '0;
      r_if_valid  <= 1'b0;
      r_flush_cnt <= r_flush_cnt + CNT_SIZE'(1);
    end else if (!bus.freeze) begin
      r_pc        <= w_pc_plus4;
      r_if_pc     <= w_pc_plus4;
      r_if_inst   <= bus.inst_in;
      r_if_valid  <= 1'b1;
      r_fetch_cnt <= r_fetch_cnt + CNT_SIZE'(1);
    end
  end

  // Only inst_addr is combinational, and it depends on the PC register alone.
  assign bus.inst_addr   = r_pc;
  assign bus.if_id_pc    = r_if_pc;
  assign bus.if_id_inst  = r_if_inst;
  assign bus.if_id_valid = r_if_valid;
  assign bus.fetch_count = r_fetch_cnt;
  assign bus.flush_count = r_flush_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table for the documented scenarios,
// then random reset/freeze/branch traffic against a behavioural model.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_if #(.ADDR_SIZE(32), .INST_SIZE(32), .CNT_SIZE(16)) bus ();

  fetch_stage #(.ADDR_SIZE(32), .INST_SIZE(32), .RESET_PC(32'h0), .CNT_SIZE(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Instruction memory contents: three fixed words, a recognisable pattern elsewhere.
  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h8020000A;
      32'h4:   return 32'h04400800;
      32'h8:   return 32'h0C600800;
      default: return {~a[15:0], a[15:0]};
    endcase
  endfunction

  assign bus.inst_in = imem(bus.inst_addr);

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    logic        rst, fz, br;
    logic [31:0] ba;
    logic [31:0] pc, ifpc, inst;
    logic        v;
    logic [15:0] fc, flc;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic f, input logic b, input logic [31:0] ba,
                              input logic [31:0] pc, input logic [31:0] ifpc, input logic [31:0] inst,
                              input logic v, input logic [15:0] fc, input logic [15:0] flc);
    vec_t t;
    t.rst = r; t.fz = f; t.br = b; t.ba = ba;
    t.pc = pc; t.ifpc = ifpc; t.inst = inst; t.v = v; t.fc = fc; t.flc = flc;
    return t;
  endfunction

  // Apply inputs mid-cycle, take one rising edge, sample 1 time unit later.
  task automatic drive_edge(input logic r, input logic f, input logic b, input logic [31:0] ba);
    rst = r; bus.freeze = f; bus.branch_taken = b; bus.branch_addr = ba;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ifpc,
                         input logic [31:0] inst, input logic v, input logic [15:0] fc,
                         input logic [15:0] flc);
    chk({tag, ".inst_addr"},   64'(bus.inst_addr),   64'(pc));
    chk({tag, ".if_id_pc"},    64'(bus.if_id_pc),    64'(ifpc));
    chk({tag, ".if_id_inst"},  64'(bus.if_id_inst),  64'(inst));
    chk({tag, ".if_id_valid"}, 64'(bus.if_id_valid), 64'(v));
    chk({tag, ".fetch_count"}, 64'(bus.fetch_count), 64'(fc));
    chk({tag, ".flush_count"}, 64'(bus.flush_count), 64'(flc));
  endtask

  // Reference state: what the stage should hold, stated as "address last fetched" rather than registers.
  logic [31:0] m_pc;
  logic        m_have;   // IF/ID holds a real instruction
  logic [31:0] m_addr;   // address of that instruction
  int          m_fc, m_flc;

  task automatic model_step(input logic r, input logic f, input logic b, input logic [31:0] ba);
    if (!r) begin
      m_pc = 32'h0; m_have = 1'b0; m_addr = 32'h0; m_fc = 0; m_flc = 0;
    end else if (b) begin
      m_pc = ba & 32'hFFFF_FFFC; m_have = 1'b0; m_flc = (m_flc + 1) % 65536;
    end else if (!f) begin
      m_addr = m_pc; m_have = 1'b1;
      m_pc = 32'((64'(m_pc) + 4) % 64'h1_0000_0000);
      m_fc = (m_fc + 1) % 65536;
    end
  endtask

  vec_t tbl[21];

  initial begin
    rst = 1'b0; bus.freeze = 1'b0; bus.branch_taken = 1'b0; bus.branch_addr = '0;

    //           rst fz br  branch_addr    pc            if_id_pc      if_id_inst    v  fc flc
    tbl[0]  = mk(0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 32'h0,        32'h4,        32'h4,        32'h8020000A, 1, 1, 0);
    tbl[2]  = mk(1, 0, 0, 32'h0,        32'h8,        32'h8,        32'h04400800, 1, 2, 0);
    tbl[3]  = mk(1, 0, 0, 32'h0,        32'hC,        32'hC,        32'h0C600800, 1, 3, 0);
    tbl[4]  = mk(0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0);
    tbl[5]  = mk(1, 0, 0, 32'h0,        32'h4,        32'h4,        32'h8020000A, 1, 1, 0);
    tbl[6]  = mk(1, 0, 0, 32'h0,        32'h8,        32'h8,        32'h04400800, 1, 2, 0);
    tbl[7]  = mk(1, 1, 0, 32'h0,        32'h8,        32'h8,        32'h04400800, 1, 2, 0);
    tbl[8]  = mk(1, 1, 0, 32'h0,        32'h8,        32'h8,        32'h04400800, 1, 2, 0);
    tbl[9]  = mk(1, 0, 0, 32'h0,        32'hC,        32'hC,        32'h0C600800, 1, 3, 0);
    tbl[10] = mk(1, 1, 1, 32'h40,       32'h40,       32'h0,        32'h0,        0, 3, 1);
    tbl[11] = mk(1, 0, 0, 32'h0,        32'h44,       32'h44,       32'hFFBF0040, 1, 4, 1);
    tbl[12] = mk(1, 0, 1, 32'h23,       32'h20,       32'h0,        32'h0,        0, 4, 2);
    tbl[13] = mk(1, 0, 0, 32'h0,        32'h24,       32'h24,       32'hFFDF0020, 1, 5, 2);
    tbl[14] = mk(1, 0, 1, 32'hFFFFFFFE, 32'hFFFFFFFC, 32'h0,        32'h0,        0, 5, 3);
    tbl[15] = mk(1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0003FFFC, 1, 6, 3);
    tbl[16] = mk(1, 0, 1, 32'h40,       32'h40,       32'h0,        32'h0,        0, 6, 4);
    tbl[17] = mk(1, 1, 0, 32'h0,        32'h40,       32'h0,        32'h0,        0, 6, 4);
    tbl[18] = mk(0, 1, 1, 32'h80,       32'h0,        32'h0,        32'h0,        0, 0, 0);
    tbl[19] = mk(1, 0, 0, 32'h0,        32'h4,        32'h4,        32'h8020000A, 1, 1, 0);
    tbl[20] = mk(1, 0, 0, 32'h0,        32'h8,        32'h8,        32'h04400800, 1, 2, 0);

    #2;
    for (int i = 0; i < 21; i++) begin
      drive_edge(tbl[i].rst, tbl[i].fz, tbl[i].br, tbl[i].ba);
      chk_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].ifpc, tbl[i].inst, tbl[i].v,
              tbl[i].fc, tbl[i].flc);
    end

    // Random traffic against the model.
    drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
    model_step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2000; i++) begin
      logic        r, f, b;
      logic [31:0] ba;
      r  = ($urandom_range(0, 40) != 0);
      f  = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 7) == 0);
      ba = (i % 3 == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
      rst = r; bus.freeze = f; bus.branch_taken = b; bus.branch_addr = ba;
      #1;
      // New inputs must not reach any output before the edge.
      if (i % 50 == 0)
        chk($sformatf("rnd%0d.pre_edge_pc", i), 64'(bus.inst_addr), 64'(m_pc));
      @(posedge clk);
      #1;
      model_step(r, f, b, ba);
      chk_all($sformatf("rnd%0d", i), m_pc,
              m_have ? 32'(m_addr + 32'd4) : 32'h0,
              m_have ? imem(m_addr) : 32'h0,
              m_have, 16'(m_fc), 16'(m_flc));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
